// File: rtl/cam_capture_pkg.sv
// Shared state type, geometry constants and colour helpers for camera_capture.
package cam_capture_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWaitVsLow,
        StFrame
    } capState_t;

    localparam int unsigned cDefHRes  = 640;
    localparam int unsigned cDefVRes  = 480;
    localparam int unsigned cBufHRes  = 320;
    localparam int unsigned cBufVRes  = 240;
    localparam int unsigned cBarCount = 8;
    localparam int unsigned cBarWidth = cBufHRes / cBarCount;

    function automatic logic [11:0] rgb565To12(input logic [15:0] d);
        return {d[15:12], d[10:7], d[4:1]};
    endfunction

    // Bar n lights R/G/B from bits 2/1/0 of n.
    function automatic logic [11:0] barColour(input logic [8:0] x);
        logic [2:0] n;
        n = 3'(x / 9'(cBarWidth));
        return {{4{n[2]}}, {4{n[1]}}, {4{n[0]}}};
    endfunction

endpackage

// File: rtl/cam_byte_assembler.sv
// Pairs camera bytes into RGB565 pixels; phase restarts at each line start.
module cam_byte_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        lineStart,
    input  logic        byteTake,
    input  logic [7:0]  byteData,
    output logic        pixDone,
    output logic [15:0] pixel,
    output logic        phaseNext
);

    logic       phase;
    logic       phaseEff;
    logic [7:0] hiByte;

    assign phaseEff  = lineStart ? 1'b0 : phase;
    assign pixDone   = byteTake & phaseEff;
    assign pixel     = {hiByte, byteData};
    assign phaseNext = phaseEff ^ byteTake;

    always_ff @(posedge clock) begin
        if (reset) begin
            phase  <= 1'b0;
            hiByte <= '0;
        end else begin
            phase <= phaseNext;
            if (byteTake && !phaseEff) begin
                hiByte <= byteData;
            end
        end
    end

endmodule

// File: rtl/camera_capture.sv
// Camera byte stream -> 2:1 decimated RGB12 draw-point writes.
// Define CAMCAPTURE_TEST_PATTERN_EN to add the colour-bar select input.
module camera_capture
    import cam_capture_pkg::*;
#(
    parameter int unsigned pHRes = cDefHRes,
    parameter int unsigned pVRes = cDefVRes
) (
    input  logic        piul1Clock,
    input  logic        piul1Reset,
    input  logic        piul1CamVSync,
    input  logic        piul1CamHRef,
    input  logic        piul1CamByteValid,
    input  logic [7:0]  piul8CamData,
`ifdef CAMCAPTURE_TEST_PATTERN_EN
    input  logic        piul1TestPatternSel,
`endif
    output logic [8:0]  poul9PosX,
    output logic [8:0]  poul9PosY,
    output logic [11:0] poul12Rgb12Data,
    output logic        poul1Update,
    output logic        poul1FrameDone,
    output logic        poul1LineError
);

    localparam logic [9:0] cHRes   = 10'(pHRes);
    localparam logic [9:0] cVRes   = 10'(pVRes);
    localparam logic [9:0] cCntMax = '1;

    capState_t   state;
    capState_t   stateNext;
    logic        vsyncQ;
    logic        hrefQ;
    logic        vsRise;
    logic        vsFall;
    logic        hrefRise;
    logic        hrefFall;
    logic        inFrame;
    logic        lineStart;
    logic        lineEnd;
    logic        byteTake;
    logic        pixDone;
    logic [15:0] pixel;
    logic        phaseNext;
    logic [9:0]  pixCnt;
    logic [9:0]  pixIdx;
    logic [9:0]  pixCntAfter;
    logic [9:0]  lineCnt;
    logic        lineErr;
    logic        abortLine;
    logic        frameBad;
    logic        frameEntry;
    logic        doneHit;
    logic        writeHit;
    logic [11:0] pixRgb;

    assign vsRise    = piul1CamVSync & ~vsyncQ;
    assign vsFall    = ~piul1CamVSync & vsyncQ;
    assign hrefRise  = piul1CamHRef & ~hrefQ;
    assign hrefFall  = ~piul1CamHRef & hrefQ;
    assign inFrame   = (state == StFrame);
    assign lineStart = inFrame & hrefRise;
    assign lineEnd   = inFrame & hrefFall;
    assign abortLine = inFrame & vsRise & piul1CamHRef;

    // hrefQ keeps the byte that arrives together with the HRef fall.
    assign byteTake = inFrame & piul1CamByteValid
                    & (piul1CamHRef | hrefQ);

    cam_byte_assembler uAsm (
        .clock     (piul1Clock),
        .reset     (piul1Reset),
        .lineStart (lineStart),
        .byteTake  (byteTake),
        .byteData  (piul8CamData),
        .pixDone   (pixDone),
        .pixel     (pixel),
        .phaseNext (phaseNext)
    );

    assign pixIdx = lineStart ? '0 : pixCnt;

    assign pixCntAfter = (pixDone && pixIdx != cCntMax)
                       ? pixIdx + 10'd1 : pixIdx;

    // Line-end check sees the count after any coincident byte.
    assign lineErr = lineEnd
                   & (phaseNext | (pixCntAfter != cHRes));

    assign writeHit = pixDone
                    && !pixIdx[0]
                    && !lineCnt[0]
                    && (pixIdx < cHRes)
                    && (lineCnt < cVRes);

`ifdef CAMCAPTURE_TEST_PATTERN_EN
    assign pixRgb = piul1TestPatternSel
                  ? barColour(pixIdx[9:1])
                  : rgb565To12(pixel);
`else
    assign pixRgb = rgb565To12(pixel);
`endif

    always_comb begin
        stateNext  = state;
        frameEntry = 1'b0;
        doneHit    = 1'b0;
        unique case (state)
            StIdle: begin
                if (vsRise) begin
                    stateNext = StWaitVsLow;
                end
            end
            StWaitVsLow: begin
                if (vsFall) begin
                    stateNext  = StFrame;
                    frameEntry = 1'b1;
                end
            end
            StFrame: begin
                if (vsRise) begin
                    stateNext = StWaitVsLow;
                    doneHit   = (lineCnt == cVRes)
                              && !frameBad
                              && !abortLine
                              && !lineErr;
                end
            end
            default: stateNext = StIdle;
        endcase
    end

    always_ff @(posedge piul1Clock) begin
        if (piul1Reset) begin
            state    <= StIdle;
            vsyncQ   <= 1'b0;
            hrefQ    <= 1'b0;
            pixCnt   <= '0;
            lineCnt  <= '0;
            frameBad <= 1'b0;
        end else begin
            state  <= stateNext;
            vsyncQ <= piul1CamVSync;
            hrefQ  <= piul1CamHRef;
            pixCnt <= pixCntAfter;
            if (frameEntry) begin
                lineCnt <= '0;
            end else if (lineEnd && lineCnt != cCntMax) begin
                lineCnt <= lineCnt + 10'd1;
            end
            if (frameEntry) begin
                frameBad <= 1'b0;
            end else if (lineErr || abortLine) begin
                frameBad <= 1'b1;
            end
        end
    end

    always_ff @(posedge piul1Clock) begin
        if (piul1Reset) begin
            poul9PosX       <= '0;
            poul9PosY       <= '0;
            poul12Rgb12Data <= '0;
            poul1Update     <= 1'b0;
            poul1FrameDone  <= 1'b0;
            poul1LineError  <= 1'b0;
        end else begin
            poul1Update    <= writeHit;
            poul1FrameDone <= doneHit;
            if (writeHit) begin
                poul9PosX       <= pixIdx[9:1];
                poul9PosY       <= lineCnt[9:1];
                poul12Rgb12Data <= pixRgb;
            end
            if (lineErr || abortLine) begin
                poul1LineError <= 1'b1;
            end else if (vsRise) begin
                poul1LineError <= 1'b0;
            end
        end
    end

endmodule
